// File: rtl/fc_input_sequencer_if.sv
// Handshake bundle between the activation stream, the FC engine and the result consumer.
// master = sequencer side, slave = environment side.
interface fc_input_sequencer_if #(
   parameter int N_ELEM = 8,
   parameter int DATA_W = 8,
   parameter int RES_W  = 16
);
   logic                     in_valid;
   logic [DATA_W-1:0]        in_data;
   logic                     in_last;
   logic                     in_ready;
   logic [N_ELEM*DATA_W-1:0] fc_input;
   logic                     fc_enable;
   logic                     fc_done;
   logic [RES_W-1:0]         fc_result;
   logic                     res_valid;
   logic [RES_W-1:0]         res_data;
   logic                     res_ready;
   logic                     err_timeout;
   logic                     busy;

   modport master (
      input  in_valid, in_data, in_last, fc_done, fc_result, res_ready,
      output in_ready, fc_input, fc_enable, res_valid, res_data, err_timeout, busy
   );

   modport slave (
      output in_valid, in_data, in_last, fc_done, fc_result, res_ready,
      input  in_ready, fc_input, fc_enable, res_valid, res_data, err_timeout, busy
   );
endinterface

// File: rtl/fc_input_sequencer.sv
// Packs an activation byte stream into one FC input vector, runs the FC engine
// until its done edge, then holds the captured result for a downstream handshake.
module fc_input_sequencer #(
   parameter int N_ELEM       = 8,
   parameter int DATA_W       = 8,
   parameter int RES_W        = 16,
   parameter int DONE_TIMEOUT = 64
) (
   input logic                  clk,
   input logic                  rst,
   fc_input_sequencer_if.master bus
);
   localparam int CNT_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam int TMR_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ELEM - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_FILL,
      S_RUN,
      S_HOLD
   } state_t;

   state_t                   state_q, state_nxt;
   logic [N_ELEM*DATA_W-1:0] buf_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [TMR_W-1:0]         timer_q;
   logic [RES_W-1:0]         res_q;
   logic                     err_q;
   logic                     done_q;

   logic done_rise;
   logic accept;
   logic close;
   logic capture;
   logic timeout;
   logic res_taken;

   // Only a fresh rising edge completes a run; a level left high from before is ignored.
   assign done_rise = bus.fc_done & ~done_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FILL;
      else     state_q <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_nxt     = state_q;
      accept        = 1'b0;
      close         = 1'b0;
      capture       = 1'b0;
      timeout       = 1'b0;
      res_taken     = 1'b0;
      bus.in_ready  = 1'b0;
      bus.fc_enable = 1'b0;
      bus.res_valid = 1'b0;
      bus.busy      = 1'b0;

      case (state_q)
         S_FILL: begin
            bus.in_ready = 1'b1;
            accept       = bus.in_valid;
            close        = accept & ((cnt_q == CNT_LAST) | bus.in_last);
            if (close) state_nxt = S_RUN;
         end
         S_RUN: begin
            bus.fc_enable = 1'b1;
            bus.busy      = 1'b1;
            if (done_rise) begin
               capture   = 1'b1;
               state_nxt = S_HOLD;
            end else if ((DONE_TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
               timeout   = 1'b1;
               state_nxt = S_FILL;
            end
         end
         S_HOLD: begin
            bus.res_valid = 1'b1;
            bus.busy      = 1'b1;
            res_taken     = bus.res_ready;
            if (res_taken) state_nxt = S_FILL;
         end
         default: state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         buf_q   <= '0;
         cnt_q   <= '0;
         timer_q <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q  <= bus.fc_done;
         err_q   <= timeout;
         timer_q <= (state_q == S_RUN) ? timer_q + 1'b1 : '0;

         if (accept) begin
            for (int k = 0; k < N_ELEM; k++) begin
               if (cnt_q == CNT_W'(k)) buf_q[k*DATA_W +: DATA_W] <= bus.in_data;
            end
            if (!close) cnt_q <= cnt_q + 1'b1;
         end

         if (capture) res_q <= bus.fc_result;

         // Clearing on frame end leaves unfilled slots of a short next frame at zero.
         if (res_taken || timeout) begin
            buf_q <= '0;
            cnt_q <= '0;
         end
      end
   end

   assign bus.fc_input    = buf_q;
   assign bus.res_data    = res_q;
   assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_fc_input_sequencer.sv
// Scoreboard bench for fc_input_sequencer: expected vectors/results are queued as
// frames are driven and compared when fc_enable rises or a result is handed over.
module tb_fc_input_sequencer;
   localparam int N_ELEM       = 8;
   localparam int DATA_W       = 8;
   localparam int RES_W        = 16;
   localparam int DONE_TIMEOUT = 16;
   localparam int VW           = N_ELEM * DATA_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   logic [VW-1:0]    exp_vec_q[$];
   logic [RES_W-1:0] exp_res_q[$];
   logic             en_prev = 1'b0;

   fc_input_sequencer_if #(.N_ELEM(N_ELEM), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

   fc_input_sequencer #(
      .N_ELEM(N_ELEM), .DATA_W(DATA_W), .RES_W(RES_W), .DONE_TIMEOUT(DONE_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one element and return just after the edge that accepts it.
   task automatic send(input logic [DATA_W-1:0] d, input logic last);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      check("send_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // One-cycle fc_done pulse during RUN, then take the held result at once.
   task automatic done_and_take(input logic [RES_W-1:0] r, input string tag);
      bus.fc_done   = 1'b1;
      bus.fc_result = r;
      tick();
      bus.fc_done = 1'b0;
      check({tag, "_enable_drop"}, bus.fc_enable, 0);
      check({tag, "_res_valid"}, bus.res_valid, 1);
      check({tag, "_res_data"}, bus.res_data, r);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check({tag, "_in_ready_after"}, bus.in_ready, 1);
      check({tag, "_res_valid_after"}, bus.res_valid, 0);
      check({tag, "_fc_input_clr"}, bus.fc_input, 0);
   endtask

   // Scoreboard: vector checked on fc_enable rise, result checked on handshake.
   always @(negedge clk) begin
      if (bus.fc_enable === 1'b1 && en_prev === 1'b0) begin
         check("sb_vec_pending", exp_vec_q.size(), 1);
         if (exp_vec_q.size() > 0) check("sb_fc_input", bus.fc_input, exp_vec_q.pop_front());
      end
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
         check("sb_res_pending", exp_res_q.size(), 1);
         if (exp_res_q.size() > 0) check("sb_res_data", bus.res_data, exp_res_q.pop_front());
      end
      en_prev <= bus.fc_enable;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  n;
      bit  seen_res;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.fc_done   = 1'b0;
      bus.fc_result = '0;
      bus.res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_in_ready", bus.in_ready, 1);
      check("rst_fc_enable", bus.fc_enable, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_err_timeout", bus.err_timeout, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_fc_input", bus.fc_input, 0);

      // Full frame 01..08, no in_last.
      exp_vec_q.push_back(64'h0807060504030201);
      exp_res_q.push_back(16'h0123);
      for (int i = 1; i <= 8; i++) send(DATA_W'(i), 1'b0);
      check("t1_enable", bus.fc_enable, 1);
      check("t1_busy", bus.busy, 1);
      check("t1_in_ready", bus.in_ready, 0);
      check("t1_fc_input", bus.fc_input, 64'h0807060504030201);
      done_and_take(16'h0123, "t1");

      // Short frame closed by in_last on the third element.
      exp_vec_q.push_back(64'h0000000000FF807F);
      exp_res_q.push_back(16'hBEEF);
      send(8'h7F, 1'b0);
      send(8'h80, 1'b0);
      send(8'hFF, 1'b1);
      check("t2_enable", bus.fc_enable, 1);
      check("t2_fc_input", bus.fc_input, 64'h0000000000FF807F);
      check("t2_in_ready", bus.in_ready, 0);
      bus.fc_done   = 1'b1;
      bus.fc_result = 16'hBEEF;
      tick();
      bus.fc_done = 1'b0;
      check("t3_res_valid", bus.res_valid, 1);

      // Downstream stalls 5 cycles while upstream keeps offering 0x55.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("t3_hold_valid", bus.res_valid, 1);
         check("t3_hold_data", bus.res_data, 16'hBEEF);
         check("t3_hold_in_ready", bus.in_ready, 0);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check("t3_in_ready_after", bus.in_ready, 1);
      check("t3_nothing_taken", bus.fc_input, 0);
      exp_vec_q.push_back(64'h0000000000006655);
      exp_res_q.push_back(16'h1111);
      tick();
      check("t3_first_slot", bus.fc_input, 64'h0000000000000055);
      send(8'h66, 1'b1);
      check("t3_enable", bus.fc_enable, 1);
      done_and_take(16'h1111, "t3b");

      // fc_done stuck low: timeout after DONE_TIMEOUT RUN cycles.
      exp_vec_q.push_back(64'hA8A7A6A5A4A3A2A1);
      for (int i = 1; i <= 8; i++) send(DATA_W'(8'hA0 + i), 1'b0);
      n        = 0;
      seen_res = 1'b0;
      while (bus.fc_enable && n < 100) begin
         seen_res |= bus.res_valid;
         check("t4_no_err_early", bus.err_timeout, 0);
         n++;
         tick();
      end
      check("t4_enable_cycles", n, DONE_TIMEOUT);
      check("t4_err_pulse", bus.err_timeout, 1);
      check("t4_in_ready", bus.in_ready, 1);
      check("t4_res_valid", bus.res_valid, 0);
      check("t4_fc_input_clr", bus.fc_input, 0);
      check("t4_no_result", seen_res, 0);
      tick();
      check("t4_err_one_cycle", bus.err_timeout, 0);

      // fc_done already high on RUN entry must not complete the run.
      exp_vec_q.push_back(64'h1716151413121110);
      exp_res_q.push_back(16'h7E57);
      bus.fc_done   = 1'b1;
      bus.fc_result = 16'h7E57;
      for (int i = 0; i < 8; i++) send(DATA_W'(8'h10 + i), 1'b0);
      for (int c = 0; c < 3; c++) begin
         check("t5_still_run", bus.fc_enable, 1);
         check("t5_no_capture", bus.res_valid, 0);
         tick();
      end
      bus.fc_done = 1'b0;
      tick();
      check("t5_run_after_fall", bus.fc_enable, 1);
      bus.fc_done = 1'b1;
      tick();
      bus.fc_done = 1'b0;
      check("t5_res_valid", bus.res_valid, 1);
      check("t5_res_data", bus.res_data, 16'h7E57);
      check("t5_enable_drop", bus.fc_enable, 0);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;

      // Reset in the middle of RUN abandons the frame.
      exp_vec_q.push_back(64'h0000000000002221);
      send(8'h21, 1'b0);
      send(8'h22, 1'b1);
      check("t6_enable", bus.fc_enable, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_enable_off", bus.fc_enable, 0);
      check("t6_res_valid", bus.res_valid, 0);
      check("t6_fc_input", bus.fc_input, 0);
      check("t6_in_ready", bus.in_ready, 1);
      check("t6_busy", bus.busy, 0);
      exp_vec_q.push_back(64'h3837363534333231);
      exp_res_q.push_back(16'h0A0A);
      for (int i = 1; i <= 8; i++) send(DATA_W'(8'h30 + i), 1'b0);
      check("t6_enable2", bus.fc_enable, 1);
      done_and_take(16'h0A0A, "t6");

      tick();
      check("end_vec_q_empty", exp_vec_q.size(), 0);
      check("end_res_q_empty", exp_res_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
